// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame scheduler: FSM encoding, frame
// layout constants and the byte-select helper used when loading tx_data.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARB     = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_WAIT_HI = 3'd3;
  localparam state_t ST_WAIT_LO = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN         = 4;

  // Frame layout: sync, channel index, sample high byte, sample low byte.
  function automatic logic [7:0] frame_byte(input logic [7:0]  sync,
                                            input logic [1:0]  ch,
                                            input logic [15:0] sample,
                                            input logic [1:0]  idx);
    case (idx)
      2'd0:    frame_byte = sync;
      2'd1:    frame_byte = {6'b0, ch};
      2'd2:    frame_byte = sample[15:8];
      default: frame_byte = sample[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Bundle of sample-request and UART-transmitter signals around the scheduler,
// plus the FSM state exposed for observation.
interface uart_frame_scheduler_if
  import uart_pkg::*;
#(
  parameter int NUM_CH = 2
) ();

  // req_valid/req_ready: a sample of channel i transfers on the rising edge
  // where req_valid[i] and req_ready[i] are both high; valid must stay up
  // until that edge, ready is a single-cycle pulse and never waits on itself.
  logic [NUM_CH-1:0]    req_valid;
  logic [16*NUM_CH-1:0] req_data;
  logic [NUM_CH-1:0]    req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 frame_busy;
  logic [15:0]          frame_count;
  state_t               dbg_state;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, frame_busy, frame_count, dbg_state
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, frame_busy, frame_count, dbg_state
  );

endinterface

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the channel after
// i_last_grant and returns the first requester as one-hot plus index.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDXW   = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDXW-1:0]   i_last_grant,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDXW-1:0]   o_grant_idx,
  output logic              o_any
);

  always_comb begin
    int c;
    c           = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int off = 1; off <= NUM_CH; off++) begin
      c = (int'(i_last_grant) + off) % NUM_CH;
      if (!o_any && i_req[c]) begin
        o_grant[c]  = 1'b1;
        o_grant_idx = IDXW'(c);
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Multiplexes per-channel 16-bit samples into 4-byte frames for a byte-wide
// UART transmitter, serving channels round-robin one frame at a time.
module uart_frame_scheduler
  import uart_pkg::*;
#(
  parameter int         NUM_CH    = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input logic                    clk,
  input logic                    reset_n,
  uart_frame_scheduler_if.master bus
);

  localparam int         IDXW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] LAST_BYTE = 2'(FRAME_LEN - 1);

  state_t            r_state;
  logic [IDXW-1:0]   r_last_grant;
  logic [IDXW-1:0]   r_ch_idx;
  logic [15:0]       r_hold;
  logic [1:0]        r_byte_idx;
  logic [1:0]        r_wait_cnt;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic [15:0]       r_frame_count;

  logic [NUM_CH-1:0] w_grant;
  logic [IDXW-1:0]   w_grant_idx;
  logic              w_any_req;
  logic [15:0]       w_sample;
  logic [1:0]        w_ch2;
  logic [7:0]        w_byte;
  logic              w_frame_done;
  logic [15:0]       w_frame_count_nxt;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDXW   (IDXW)
  ) u_arb (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any_req)
  );

  assign w_sample          = bus.req_data[{w_grant_idx, 4'b0000} +: 16];
  assign w_ch2             = 2'(r_ch_idx);
  assign w_byte            = frame_byte(SYNC_BYTE, w_ch2, r_hold, r_byte_idx);
  assign w_frame_done      = (r_state == ST_WAIT_LO) && !bus.tx_busy &&
                             (r_byte_idx == LAST_BYTE);
  assign w_frame_count_nxt = r_frame_count + {15'd0, w_frame_done};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= IDXW'(NUM_CH - 1);
      r_ch_idx      <= '0;
      r_hold        <= '0;
      r_byte_idx    <= '0;
      r_wait_cnt    <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_frame_count <= '0;
    end else begin
      r_tx_start    <= 1'b0;
      r_frame_count <= w_frame_count_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (w_any_req) begin
            r_hold     <= w_sample;
            r_ch_idx   <= w_grant_idx;
            r_byte_idx <= '0;
            r_state    <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_tx_data  <= w_byte;
          r_tx_start <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT_HI;
        end
        // A transmitter that never acknowledges within four cycles gets the
        // same byte offered again rather than stalling the frame forever.
        ST_WAIT_HI: begin
          if (bus.tx_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (r_wait_cnt == 2'd3) begin
            r_state <= ST_LOAD;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (r_byte_idx != LAST_BYTE) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= ST_LOAD;
            end else begin
              r_last_grant <= r_ch_idx;
              r_state      <= w_any_req ? ST_ARB : ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == ST_ARB) ? w_grant : '0;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.frame_busy  = ((r_state == ST_ARB) && w_any_req) ||
                           (r_state == ST_LOAD) ||
                           (r_state == ST_WAIT_HI) ||
                           (r_state == ST_WAIT_LO);
  assign bus.frame_count = r_frame_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: UART transmitter model with byte scoreboard,
// per-scenario tasks run in sequence, one summary line at the end.
module tb_uart_frame_scheduler;
  import uart_pkg::*;

  localparam int NUM_CH = 2;

  logic clk;
  logic reset_n;

  uart_frame_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  uart_frame_scheduler #(
    .NUM_CH    (NUM_CH),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] start_data_q[$];
  int         start_cyc_q[$];
  int         ready_cnt[NUM_CH] = '{default: 0};

  int busy_len    = 3;
  int busy_cnt    = 0;
  int drop_starts = 0;
  bit start_pend  = 1'b0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- UART transmitter model + scoreboard ----------------
  initial begin
    logic       busy_before;
    logic [7:0] exp;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        bus.tx_busy = 1'b0;
        busy_cnt    = 0;
        start_pend  = 1'b0;
      end else begin
        busy_before = bus.tx_busy;
        if (start_pend) begin
          bus.tx_busy = 1'b1;
          busy_cnt    = busy_len;
          start_pend  = 1'b0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) bus.tx_busy = 1'b0;
        end
        if (bus.tx_start === 1'b1) begin
          checks++;
          if (busy_before !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy: tx_busy=%b, required 0", busy_before);
          end
          start_data_q.push_back(bus.tx_data);
          start_cyc_q.push_back(cyc);
          if (drop_starts > 0) begin
            drop_starts--;
          end else begin
            start_pend = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL tx_byte: got %h, required no byte", bus.tx_data);
            end else begin
              exp = exp_q.pop_front();
              if (bus.tx_data !== exp) begin
                errors++;
                $display("FAIL tx_byte: got %h, required %h", bus.tx_data, exp);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++)
        if (bus.req_ready[c] === 1'b1) ready_cnt[c]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int ch, input logic [15:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(ch));
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic send_sample(input int ch, input logic [15:0] d, output int t_set);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bus.req_data[16*ch +: 16] = d;
    bus.req_valid[ch]         = 1'b1;
    t_set                     = cyc;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[ch] === 1'b1) begin
        got = 1'b1;
        push_frame(ch, d);
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_ready_timeout: ch%0d ready=0, required a pulse", ch);
    end
    @(negedge clk);
    bus.req_valid[ch]         = 1'b0;
    bus.req_data[16*ch +: 16] = ~d;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.dbg_state === ST_IDLE && bus.tx_busy === 1'b0)
        done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle_timeout: state=%0d pending=%0d, required idle 0", name,
               bus.dbg_state, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks += 6;
    if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b, required 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h, required 00", bus.tx_data); end
    if (bus.req_ready !== '0) begin errors++; $display("FAIL rst_req_ready: got %b, required 0", bus.req_ready); end
    if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL rst_frame_busy: got %b, required 0", bus.frame_busy); end
    if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count: got %0d, required 0", bus.frame_count); end
    if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d, required %0d", bus.dbg_state, ST_IDLE); end
  endtask

  task automatic test_single_frame();
    int t0;
    int r0;
    int lat;
    r0 = ready_cnt[0];
    start_cyc_q.delete();
    start_data_q.delete();
    send_sample(0, 16'h1234, t0);
    checks++;
    if (bus.frame_busy !== 1'b1) begin errors++; $display("FAIL single_frame_busy: got %b, required 1", bus.frame_busy); end
    wait_idle("single");
    lat = (start_cyc_q.size() > 0) ? start_cyc_q[0] - t0 : -1;
    checks += 5;
    if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d, required 3", lat); end
    if (start_cyc_q.size() != 4) begin errors++; $display("FAIL single_starts: got %0d, required 4", start_cyc_q.size()); end
    if (ready_cnt[0] - r0 != 1) begin errors++; $display("FAIL single_ready_pulses: got %0d, required 1", ready_cnt[0] - r0); end
    if (bus.frame_count !== 16'd1) begin errors++; $display("FAIL single_frame_count: got %0d, required 1", bus.frame_count); end
    if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b, required 0", bus.frame_busy); end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int exp_order[3] = '{0, 1, 0};
    do_reset();
    @(negedge clk);
    bus.req_data  = {16'h5555, 16'hAAAA};
    bus.req_valid = 2'b11;
    for (int i = 0; i < 600 && order.size() < 3; i++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++)
        if (bus.req_ready[c] === 1'b1) begin
          order.push_back(c);
          push_frame(c, (c == 0) ? 16'hAAAA : 16'h5555);
        end
    end
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("b2b");
    checks++;
    if (order.size() != 3) begin errors++; $display("FAIL b2b_grants: got %0d, required 3", order.size()); end
    for (int i = 0; i < 3 && i < order.size(); i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got ch%0d, required ch%0d", i, order[i], exp_order[i]);
      end
    end
    checks++;
    if (bus.frame_count !== 16'd3) begin errors++; $display("FAIL b2b_frame_count: got %0d, required 3", bus.frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    bit reached;
    reached = 1'b0;
    start_data_q.delete();
    send_sample(1, 16'hBEEF, t0);
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (start_data_q.size() >= 3) reached = 1'b1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL midrst_reach_byte2: got %0d starts, required 3", start_data_q.size()); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks += 6;
    if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start: got %b, required 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data: got %h, required 00", bus.tx_data); end
    if (bus.req_ready !== '0) begin errors++; $display("FAIL midrst_req_ready: got %b, required 0", bus.req_ready); end
    if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL midrst_frame_busy: got %b, required 0", bus.frame_busy); end
    if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL midrst_frame_count: got %0d, required 0", bus.frame_count); end
    if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d, required %0d", bus.dbg_state, ST_IDLE); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_data_q.delete();
    checks++;
    if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL midrst_count_after: got %0d, required 0", bus.frame_count); end
    send_sample(0, 16'h0F0F, t0);
    wait_idle("midrst");
    checks += 2;
    if (start_data_q.size() != 4) begin errors++; $display("FAIL midrst_starts: got %0d, required 4", start_data_q.size()); end
    if (bus.frame_count !== 16'd1) begin errors++; $display("FAIL midrst_count_done: got %0d, required 1", bus.frame_count); end
  endtask

  task automatic test_retry();
    int t0;
    int gap;
    start_data_q.delete();
    start_cyc_q.delete();
    drop_starts = 1;
    send_sample(1, 16'hC33C, t0);
    wait_idle("retry");
    gap = (start_cyc_q.size() > 1) ? start_cyc_q[1] - start_cyc_q[0] : -1;
    checks += 3;
    if (start_data_q.size() != 5) begin errors++; $display("FAIL retry_starts: got %0d, required 5", start_data_q.size()); end
    if (gap != 5) begin errors++; $display("FAIL retry_gap: got %0d cycles, required 5", gap); end
    if (start_data_q.size() < 2 || start_data_q[0] !== 8'hA5 || start_data_q[1] !== 8'hA5) begin
      errors++;
      $display("FAIL retry_same_byte: first two starts differ from A5, required A5 A5");
    end
  endtask

  task automatic test_wrap();
    int t0;
    @(negedge clk);
    force dut.w_frame_count_nxt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.w_frame_count_nxt;
    @(negedge clk);
    checks++;
    if (bus.frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h, required ffff", bus.frame_count); end
    send_sample(0, 16'h8001, t0);
    wait_idle("wrap");
    checks++;
    if (bus.frame_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h, required 0000", bus.frame_count); end
  endtask

  task automatic test_withdrawn();
    int s0;
    int r0;
    s0 = start_data_q.size();
    r0 = ready_cnt[0] + ready_cnt[1];
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.dbg_state !== ST_ARB) begin errors++; $display("FAIL withdraw_arb: got %0d, required %0d", bus.dbg_state, ST_ARB); end
    if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL withdraw_busy: got %b, required 0", bus.frame_busy); end
    repeat (8) @(negedge clk);
    checks += 3;
    if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL withdraw_idle: got %0d, required %0d", bus.dbg_state, ST_IDLE); end
    if (start_data_q.size() != s0) begin errors++; $display("FAIL withdraw_tx_start: got %0d starts, required %0d", start_data_q.size(), s0); end
    if (ready_cnt[0] + ready_cnt[1] != r0) begin errors++; $display("FAIL withdraw_ready: got %0d pulses, required %0d", ready_cnt[0] + ready_cnt[1], r0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_retry();
    test_wrap();
    test_withdrawn();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_bytes: got %0d, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_scheduler.md
UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of sample requesters (legal 2..4).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning first byte of every frame.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  NUM_CH  per-channel sample available.
REQ-006 SHALL have port req_data  input  16*NUM_CH  channel i sample at bits [16i+15:16i].
REQ-007 SHALL have port req_ready  output  NUM_CH  one-cycle pulse, sample of channel i captured.
REQ-008 SHALL have port tx_start  output  1  one-cycle pulse to the UART transmitter.
REQ-009 SHALL have port tx_data  output  8  byte to transmit, stable from tx_start until tx_busy falls.
REQ-010 SHALL have port tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start, falls after the stop bit.
REQ-011 SHALL have port frame_busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port frame_count  output  16  frames completed, wraps 16'hFFFF -> 0.

Function
REQ-013 SHALL frame each sample as 4 bytes in order: SYNC_BYTE, {6'b0, channel index}, sample[15:8], sample[7:0].
REQ-014 SHALL implement states IDLE, ARB, LOAD, WAIT_HI, WAIT_LO.
REQ-015 IDLE: if any req_valid bit is high, SHALL go to ARB next cycle; otherwise stay.
REQ-016 ARB: SHALL grant round-robin starting at the channel after last_grant; SHALL capture that channel's req_data into a 16-bit holding register, pulse its req_ready for exactly this cycle, set byte_idx=0, and go to LOAD.
REQ-017 ARB with req_valid all-zero (valid withdrawn) SHALL return to IDLE without pulsing req_ready.
REQ-018 LOAD: SHALL drive tx_data with byte byte_idx, pulse tx_start for one cycle, and go to WAIT_HI.
REQ-019 WAIT_HI: SHALL hold until tx_busy=1, then go to WAIT_LO; if tx_busy stays 0 for 4 cycles, SHALL return to LOAD and re-pulse tx_start with the same byte.
REQ-020 WAIT_LO: on tx_busy=0, if byte_idx<3 SHALL increment byte_idx and go to LOAD; if byte_idx=3 SHALL increment frame_count, update last_grant, and go to ARB if any req_valid is high, else IDLE.
REQ-021 SHALL never pulse tx_start while tx_busy=1.
REQ-022 Simultaneous valids SHALL be served one frame each in rotation; no channel is granted twice while another valid channel waits.
REQ-023 req_data changes after the req_ready pulse SHALL NOT affect the frame in flight.
REQ-024 frame_busy SHALL be 1 in ARB (when granting), LOAD, WAIT_HI, and WAIT_LO, else 0.
REQ-025 Latency req_valid rise (IDLE) -> tx_start for the sync byte SHALL be 3 cycles.

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, tx_start=0, tx_data=0, req_ready=0, frame_busy=0, frame_count=0, byte_idx=0, last_grant=NUM_CH-1 (channel 0 first).
REQ-027 Reset mid-frame SHALL abandon the frame without completing it; the captured sample is lost and not retransmitted.

Structure
REQ-028 State encoding, SYNC_BYTE default, and frame length (4) SHALL live in a shared package uart_pkg.
REQ-029 The round-robin grant SHALL be a sub-module rr_arbiter (request vector, last_grant in; one-hot grant plus index out, combinational).
REQ-030 The block SHALL connect tx_start, tx_data, and tx_busy directly to the existing UART transmitter with no glue logic.

Verification
REQ-031 Ch0 valid, data 16'h1234 -> tx bytes A5,00,12,34; one req_ready[0] pulse; frame_count=1.
REQ-032 Ch0 and ch1 valid continuously, data 16'hAAAA and 16'h5555 -> frames alternate ch0, ch1, ch0; no back-to-back ch0.
REQ-033 Reset_n pulsed low during byte 2 -> all outputs zero at once; after release, next frame starts with A5 and frame_count=0.
REQ-034 tx_busy model withholds its rise for 6 cycles -> tx_start re-pulsed after 4 cycles with the same tx_data; byte order preserved.
REQ-035 frame_count preset by 65535 frames (or forced) -> next frame wraps to 0.
REQ-036 req_valid pulsed for 1 cycle then dropped before ARB -> return to IDLE, no tx_start, no req_ready.
